cmos_capture_ctrl: RTL and testbench
====================================

// Module: cmos_capture_ctrl
// PURPOSE
// Frame-capture sequencer between the CMOS camera interface (or its stimulus generator) and the SDRAM write FIFO.
// Arms on command, synchronises to the next frame start (vsyn falling) and packs href-qualified byte pairs into 16-bit RGB565 words.
// Counts pixels and lines, and closes the frame after VER_NUM lines.
// Reports frame completion, frame count and sticky error flags. Supports single-shot and continuous capture.
// PARAMETERS
// HOR_NUM   512  pixels (16-bit words) per line; one pixel = 2 href-qualified bytes
// VER_NUM   8    lines per frame
// FCNT_W    16   width of frame counter
// PORTS
// cmos_pclk   in   1       pixel clock; all logic on posedge
// rst         in   1       asynchronous, active-high reset
// cap_start   in   1       1-cycle pulse: start capture (IDLE only, ignored otherwise)
// cap_stop    in   1       1-cycle pulse: abort to IDLE from any state
// cap_cont    in   1       1 = continuous (re-arm after each frame), 0 = single shot; sampled at frame end
// err_clr     in   1       1-cycle pulse: clear sticky error flags
// cmos_data   in   8       camera byte, high byte first
// cmos_href   in   1       line valid, byte qualifier
// cmos_vsyn   in   1       frame sync, active high between frames
// pix_full    in   1       downstream FIFO full
// pix_data    out  16      packed pixel {first byte, second byte}
// pix_wr      out  1       1-cycle write strobe for pix_data
// frame_done  out  1       1-cycle pulse at end of a complete frame
// frame_cnt   out  FCNT_W  completed frames, wraps at 2^FCNT_W
// busy        out  1       state != IDLE
// line_err    out  1       sticky: a line had != HOR_NUM pixels or an odd byte count
// frame_err   out  1       sticky: vsyn rose before VER_NUM lines completed
// ovf         out  1       sticky: pixel completed while pix_full=1 (pixel dropped)
// BEHAVIOUR
// - Reset: state=IDLE, all outputs 0, pix_data=0, counters and byte phase cleared.
// - Inputs are registered once (vs_d, hr_d, dat_d); all decisions use the registered copies; vsyn edges come from vs_d vs its previous value.
// - IDLE: cap_start -> ARM. ARM: wait for vsyn falling edge -> CAPTURE with pix_cnt=0, line_cnt=0, phase=0.
//   A falling edge already in progress at arm time is not used; the block waits for the next one.
// - CAPTURE: each cycle with hr_d=1 toggles phase. phase 0 latches the high byte.
//   phase 1 completes the word: pix_wr=1 with pix_data={hi,dat_d} on the following edge.
//   Latency: the pixel is written 2 cycles after its low byte is present on cmos_data.
// - A word is written only if pix_cnt < HOR_NUM and pix_full=0. If pix_full=1, the word is dropped, ovf is set and pix_cnt still increments.
//   Words beyond HOR_NUM are discarded and line_err is set.
// - href falling edge (end of line): line_err is set if pix_cnt != HOR_NUM or phase=1. Then pix_cnt=0, phase=0, line_cnt+1.
// - When line_cnt reaches VER_NUM -> DONE for 1 cycle: frame_done=1, frame_cnt+1.
//   Then ARM if cap_cont=1, else IDLE.
// - vsyn rising while in CAPTURE with line_cnt < VER_NUM: frame_err set, no frame_done, frame_cnt unchanged, -> ARM. Any partial line is discarded.
// - cap_stop has priority over every transition and over cap_start: IDLE next cycle. No pix_wr after that cycle; counters cleared, frame_cnt kept.
// - err_clr clears line_err, frame_err and ovf; a set condition in the same cycle wins.
// - href with vsyn high, or outside CAPTURE, is ignored.
// - States: IDLE, ARM, CAPTURE, DONE; 2-bit encoding; unused codes return to IDLE.
// TESTING
// - Generator timing: HOR_NUM=512, VER_NUM=8, 100 idle cycles + 1024 href bytes per line, vsyn high 1001 cycles.
//   cap_start, cap_cont=0 -> 4096 pix_wr strobes, 1 frame_done, frame_cnt=1, no errors, then IDLE.
// - Incrementing bytes 0x80,0x00,0x80,0x01 -> pix_data 0x8000 then 0x8001, each 2 cycles after its low byte.
// - cap_cont=1 over 3 frames -> frame_cnt=3, 3 frame_done pulses, busy stays 1; then cap_stop mid-line -> IDLE next cycle, no further pix_wr.
// - Line with 1023 bytes, or 513 pixels -> line_err=1, only 512 writes in that line; err_clr -> 0.
// - vsyn rises after 5 lines -> frame_err=1, no frame_done, next frame captured fully.
// - pix_full held high for 3 pixel slots -> 3 writes missing, ovf=1; assert rst mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/cmos_capture_ctrl.sv
// cmos_capture_ctrl: frame-capture sequencer from the CMOS byte stream to the pixel write FIFO.
// Latency: a pixel is written 2 pclk after its low byte is on cmos_data. No stall: pix_full drops the word and sets ovf.
// Ports: cap_start/cap_stop/cap_cont/err_clr control; cmos_data/href/vsyn camera in; pix_data/pix_wr out;
//        frame_done/frame_cnt/busy status; line_err/frame_err/ovf sticky error flags.
module cmos_capture_ctrl #(
  parameter int HOR_NUM = 512,
  parameter int VER_NUM = 8,
  parameter int FCNT_W  = 16
) (
  input  logic              cmos_pclk,
  input  logic              rst,
  input  logic              cap_start,
  input  logic              cap_stop,
  input  logic              cap_cont,
  input  logic              err_clr,
  input  logic [7:0]        cmos_data,
  input  logic              cmos_href,
  input  logic              cmos_vsyn,
  input  logic              pix_full,
  output logic [15:0]       pix_data,
  output logic              pix_wr,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy,
  output logic              line_err,
  output logic              frame_err,
  output logic              ovf
);

  // pix_cnt needs one code above HOR_NUM so overlong lines stay detectable.
  localparam int PW = $clog2(HOR_NUM + 2);
  localparam int LW = $clog2(VER_NUM + 1);
  localparam logic [PW-1:0] HOR_CNT   = PW'(HOR_NUM);
  localparam logic [PW-1:0] PIX_SAT   = PW'(HOR_NUM + 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(VER_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                vs_q, vs_d, hr_q, hr_d;
  logic                vs_prev_q, vs_prev_d, hr_prev_q, hr_prev_d;
  logic [7:0]          dat_q, dat_d, hi_q, hi_d;
  logic                phase_q, phase_d;
  logic [PW-1:0]       pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]       line_cnt_q, line_cnt_d;
  logic [15:0]         pix_data_q, pix_data_d;
  logic                pix_wr_q, pix_wr_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                line_err_q, line_err_d;
  logic                frame_err_q, frame_err_d;
  logic                ovf_q, ovf_d;

  logic vs_rise, vs_fall, hr_fall, hr_byte;

  // Edges come from the registered copies only; href is ignored while vsyn is high.
  assign vs_rise = vs_q & ~vs_prev_q;
  assign vs_fall = ~vs_q & vs_prev_q;
  assign hr_fall = hr_prev_q & ~hr_q & ~vs_q;
  assign hr_byte = hr_q & ~vs_q;

  always_comb begin
    state_d     = state_q;
    vs_d        = cmos_vsyn;
    hr_d        = cmos_href;
    dat_d       = cmos_data;
    vs_prev_d   = vs_q;
    hr_prev_d   = hr_q;
    hi_d        = hi_q;
    phase_d     = phase_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    pix_data_d  = pix_data_q;
    pix_wr_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    // Clear first so that a set condition in the same cycle wins.
    line_err_d  = line_err_q  & ~err_clr;
    frame_err_d = frame_err_q & ~err_clr;
    ovf_d       = ovf_q       & ~err_clr;

    case (state_q)
      S_IDLE: begin
        if (cap_start) state_d = S_ARM;
      end
      S_ARM: begin
        if (vs_fall) begin
          state_d    = S_CAPTURE;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          phase_d    = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (vs_rise) begin
          // Early frame end: the frame is abandoned, including any partial line.
          frame_err_d = 1'b1;
          state_d     = S_ARM;
          pix_cnt_d   = '0;
          line_cnt_d  = '0;
          phase_d     = 1'b0;
        end else if (hr_fall) begin
          if (pix_cnt_q != HOR_CNT || phase_q) line_err_d = 1'b1;
          pix_cnt_d  = '0;
          phase_d    = 1'b0;
          line_cnt_d = line_cnt_q + LW'(1);
          if (line_cnt_q == LAST_LINE) state_d = S_DONE;
        end else if (hr_byte) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = dat_q;
          end else begin
            if (pix_cnt_q < HOR_CNT) begin
              if (pix_full) begin
                ovf_d = 1'b1;
              end else begin
                pix_wr_d   = 1'b1;
                pix_data_d = {hi_q, dat_q};
              end
            end else begin
              line_err_d = 1'b1;
            end
            // Saturate one past HOR_NUM; the exact overrun length is irrelevant.
            if (pix_cnt_q != PIX_SAT) pix_cnt_d = pix_cnt_q + PW'(1);
          end
        end
      end
      S_DONE: begin
        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        line_cnt_d  = '0;
        state_d     = cap_cont ? S_ARM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cap_stop) begin
      state_d    = S_IDLE;
      pix_wr_d   = 1'b0;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      phase_d    = 1'b0;
    end
  end

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      hr_q        <= 1'b0;
      dat_q       <= '0;
      vs_prev_q   <= 1'b0;
      hr_prev_q   <= 1'b0;
      hi_q        <= '0;
      phase_q     <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      pix_data_q  <= '0;
      pix_wr_q    <= 1'b0;
      frame_cnt_q <= '0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vs_d;
      hr_q        <= hr_d;
      dat_q       <= dat_d;
      vs_prev_q   <= vs_prev_d;
      hr_prev_q   <= hr_prev_d;
      hi_q        <= hi_d;
      phase_q     <= phase_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      pix_data_q  <= pix_data_d;
      pix_wr_q    <= pix_wr_d;
      frame_cnt_q <= frame_cnt_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_wr     = pix_wr_q;
  assign frame_done = (state_q == S_DONE);
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != S_IDLE);
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// tb_cmos_capture_ctrl: directed bench for the capture sequencer.
// Drives a camera-like byte stream (even byte 0x80, odd byte = pixel index) on the falling edge.
// Observes outputs 2 ns after each rising edge.
`timescale 1ns/1ps
module tb_cmos_capture_ctrl;
  localparam int HOR = 512;
  localparam int VER = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cap_start = 1'b0, cap_stop = 1'b0, cap_cont = 1'b0, err_clr = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        href = 1'b0, vsyn = 1'b0, pix_full = 1'b0;
  logic [15:0] pix_data;
  logic        pix_wr, frame_done, busy, line_err, frame_err, ovf;
  logic [15:0] frame_cnt;

  cmos_capture_ctrl #(.HOR_NUM(HOR), .VER_NUM(VER), .FCNT_W(16)) dut (
    .cmos_pclk(clk), .rst(rst), .cap_start(cap_start), .cap_stop(cap_stop),
    .cap_cont(cap_cont), .err_clr(err_clr), .cmos_data(data), .cmos_href(href),
    .cmos_vsyn(vsyn), .pix_full(pix_full), .pix_data(pix_data), .pix_wr(pix_wr),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy),
    .line_err(line_err), .frame_err(frame_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int tests_run = 0, tests_failed = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] outs();
    return {pix_data, pix_wr, frame_done, busy, line_err, frame_err, ovf, frame_cnt};
  endfunction

  // Monitor: counts strobes and checks the data pattern while enabled.
  int          cyc = 0, wr_cnt = 0, done_cnt = 0, busy_low = 0, data_err = 0;
  int          wr_cyc[2];
  logic [15:0] wr_dat[2];
  bit          chk_dat = 1'b0, watch_busy = 1'b0;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (pix_wr === 1'b1) begin
      if (wr_cnt < 2) begin
        wr_cyc[wr_cnt] = cyc;
        wr_dat[wr_cnt] = pix_data;
      end
      if (chk_dat && pix_data !== {8'h80, 8'(wr_cnt % HOR)}) data_err++;
      wr_cnt++;
    end
    if (frame_done === 1'b1) done_cnt++;
    if (watch_busy && busy !== 1'b1) busy_low++;
  end

  // Stimulus
  int lo_cyc[2];
  bit rec_lat = 1'b0;
  int full_at = -1;

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      href = 1'b0;
    end
  endtask

  task automatic gen_bytes(input int first, input int n);
    for (int b = first; b < first + n; b++) begin
      @(negedge clk);
      href     = 1'b1;
      data     = (b % 2 == 1) ? 8'(b / 2) : 8'h80;
      pix_full = (full_at >= 0 && b >= full_at && b < full_at + 6);
      if (rec_lat && b == 1) lo_cyc[0] = cyc;
      if (rec_lat && b == 3) begin
        lo_cyc[1] = cyc;
        rec_lat   = 1'b0;
      end
    end
  endtask

  task automatic gen_line(input int nbytes);
    idle(100);
    gen_bytes(0, nbytes);
    @(negedge clk);
    href     = 1'b0;
    pix_full = 1'b0;
  endtask

  task automatic vsync_gap(input int n);
    repeat (n) begin
      @(negedge clk);
      vsyn = 1'b1;
      href = 1'b0;
    end
    @(negedge clk);
    vsyn = 1'b0;
  endtask

  task automatic frame_lines(input int n);
    for (int l = 0; l < n; l++) gen_line(2 * HOR);
    idle(20);
  endtask

  task automatic pulse_start();
    @(negedge clk); cap_start = 1'b1;
    @(negedge clk); cap_start = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  int w0, d0;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(outs()), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Single-shot frame with full generator timing
    cap_cont = 1'b0;
    pulse_start();
    chk("arm_busy", 64'(busy), 64'd1);
    w0 = wr_cnt; d0 = done_cnt;
    chk_dat = 1'b1; rec_lat = 1'b1;
    vsync_gap(1001);
    frame_lines(VER);
    chk("single_writes", 64'(wr_cnt - w0), 64'd4096);
    chk("single_done",   64'(done_cnt - d0), 64'd1);
    chk("single_fcnt",   64'(frame_cnt), 64'd1);
    chk("single_errs",   64'({line_err, frame_err, ovf}), 64'd0);
    chk("single_idle",   64'(busy), 64'd0);
    chk("lat_word0",     64'(wr_cyc[0] - lo_cyc[0]), 64'd2);
    chk("lat_word1",     64'(wr_cyc[1] - lo_cyc[1]), 64'd2);
    chk("data_word0",    64'(wr_dat[0]), 64'h8000);
    chk("data_word1",    64'(wr_dat[1]), 64'h8001);

    // Continuous capture over 3 frames from a fresh reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cap_cont = 1'b1;
    pulse_start();
    watch_busy = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    repeat (3) begin
      vsync_gap(50);
      frame_lines(VER);
    end
    watch_busy = 1'b0;
    chk_dat = 1'b0;
    chk("cont_writes",    64'(wr_cnt - w0), 64'd12288);
    chk("cont_done",      64'(done_cnt - d0), 64'd3);
    chk("cont_fcnt",      64'(frame_cnt), 64'd3);
    chk("cont_busy_held", 64'(busy_low), 64'd0);
    chk("data_pattern",   64'(data_err), 64'd0);

    // cap_stop mid-line: the word completing in the stop cycle is not written
    vsync_gap(50);
    w0 = wr_cnt;
    idle(100);
    gen_bytes(0, 300);
    @(negedge clk); href = 1'b1; data = 8'h80; cap_stop = 1'b1;
    @(negedge clk); cap_stop = 1'b0; data = 8'd150;
    chk("stop_idle", 64'(busy), 64'd0);
    gen_bytes(302, 100);
    @(negedge clk); href = 1'b0;
    idle(5);
    chk("stop_writes", 64'(wr_cnt - w0), 64'd149);
    chk("stop_fcnt",   64'(frame_cnt), 64'd3);

    // Short and long lines
    cap_cont = 1'b0;
    pulse_start();
    vsync_gap(50);
    d0 = done_cnt;
    w0 = wr_cnt;
    gen_line(1023);
    idle(3);
    chk("odd_line_err",    64'(line_err), 64'd1);
    chk("odd_line_writes", 64'(wr_cnt - w0), 64'd511);
    pulse_clr();
    chk("err_clr_line", 64'(line_err), 64'd0);
    w0 = wr_cnt;
    gen_line(1026);
    idle(3);
    chk("long_line_writes", 64'(wr_cnt - w0), 64'd512);
    chk("long_line_err",    64'(line_err), 64'd1);
    pulse_clr();
    frame_lines(VER - 2);
    chk("lerr_frame_done", 64'(done_cnt - d0), 64'd1);
    chk("lerr_fcnt",       64'(frame_cnt), 64'd4);
    chk("lerr_clean",      64'(line_err), 64'd0);

    // vsyn rises after 5 lines, then a complete frame follows
    pulse_start();
    d0 = done_cnt;
    vsync_gap(50);
    for (int l = 0; l < 5; l++) gen_line(2 * HOR);
    idle(20);
    vsync_gap(50);
    chk("short_frame_err",  64'(frame_err), 64'd1);
    chk("short_frame_done", 64'(done_cnt - d0), 64'd0);
    chk("short_frame_fcnt", 64'(frame_cnt), 64'd4);
    w0 = wr_cnt;
    frame_lines(VER);
    chk("recover_writes", 64'(wr_cnt - w0), 64'd4096);
    chk("recover_done",   64'(done_cnt - d0), 64'd1);
    chk("recover_fcnt",   64'(frame_cnt), 64'd5);
    pulse_clr();
    chk("err_clr_frame", 64'(frame_err), 64'd0);

    // pix_full over 3 pixel slots, then reset in the middle of a line
    cap_cont = 1'b1;
    pulse_start();
    vsync_gap(50);
    w0 = wr_cnt;
    full_at = 200;
    gen_line(2 * HOR);
    full_at = -1;
    frame_lines(VER - 1);
    chk("ovf_writes", 64'(wr_cnt - w0), 64'd4093);
    chk("ovf_flag",   64'(ovf), 64'd1);
    chk("ovf_no_lerr", 64'(line_err), 64'd0);
    chk("ovf_fcnt",   64'(frame_cnt), 64'd6);
    vsync_gap(50);
    idle(100);
    gen_bytes(0, 201);
    #2 rst = 1'b1;
    #1 chk("midline_reset", 64'(outs()), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    href = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
